// File: rtl/pc_gen_if.sv
// Fetch-side bus of the program-counter generator: redirect inputs from the
// stall controller and branch unit, fetch address and status back out.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  flush_target;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_address_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               pc_misalign;
  logic               redirect_pending;

  // Driver side: pipeline control and branch unit.
  modport master (
    output stall, flush, flush_target, branch_flag_i, branch_target_address_i,
    input  pc, ce, pc_misalign, redirect_pending
  );

  // PC generator side.
  modport slave (
    input  stall, flush, flush_target, branch_flag_i, branch_target_address_i,
    output pc, ce, pc_misalign, redirect_pending
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage. Produces the registered fetch
// address and instruction-memory enable, with flush, branch and a held
// branch (captured while IF was stalled) as redirect sources.
module pc_gen #(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              STEP       = 4,
  parameter int              STALL_W    = 6,
  parameter int              ALIGN_BITS = 2
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  typedef enum logic {BOOT, RUN} state_e;

  // Keeps the low-bit slice legal when the alignment check is disabled.
  localparam int MASK_W = (ALIGN_BITS > 0) ? ALIGN_BITS : 1;
  localparam logic CHECK_ALIGN = (ALIGN_BITS > 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_q, pend_d;
  logic              ce_q, ce_d;
  logic              misalign_q, misalign_d;

  // Next-state selection: boot hand-off, then strict redirect priority in RUN.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    ce_d        = ce_q;

    unique case (state_q)
      BOOT: begin
        // First edge out of reset fetches RESET_VEC; redirects are ignored.
        state_d = RUN;
        ce_d    = 1'b1;
        pc_d    = RESET_VEC;
      end
      RUN: begin
        ce_d = 1'b1;
        if (bus.flush) begin
          pc_d   = bus.flush_target;
          pend_d = 1'b0;
        end else if (bus.stall[0]) begin
          // IF frozen: hold pc, remember the most recent taken branch.
          if (bus.branch_flag_i) begin
            pend_addr_d = bus.branch_target_address_i;
            pend_d      = 1'b1;
          end
        end else if (bus.branch_flag_i) begin
          // A live branch supersedes any held one.
          pc_d   = bus.branch_target_address_i;
          pend_d = 1'b0;
        end else if (pend_q) begin
          pc_d   = pend_addr_q;
          pend_d = 1'b0;
        end else begin
          pc_d = pc_q + ADDR_W'(STEP);
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // Status computed from the next pc so it registers alongside it.
    misalign_d = ce_d && CHECK_ALIGN && (pc_d[MASK_W-1:0] != '0);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VEC;
      pend_addr_q <= '0;
      pend_q      <= 1'b0;
      ce_q        <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      pend_q      <= pend_d;
      ce_q        <= ce_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.ce               = ce_q;
  assign bus.pc_misalign      = misalign_q;
  assign bus.redirect_pending = pend_q;

endmodule
